hv_sign_packer: RTL and testbench

- Read-out end of the bipolar accumulation path. The per-lane counters integrate core results, and each exposes only a sign bit.
- After an accumulation phase, this block waits for the counter pipeline to drain. It then snapshots all DIM sign bits and clears the counters.
- It streams the snapshot as WORD-bit words over a valid/ready master interface toward the DMA write path.

---
 rtl/hv_sign_packer.sv | 154 +++++++++++++++
 tb/tb_hv_sign_packer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hv_sign_packer.sv
// Read-out end of the bipolar accumulation path: waits for the counter pipeline to drain,
// snapshots every lane's sign bit while clearing the counters, then streams the snapshot as words.
module hv_sign_packer #(
  parameter int DIM       = 1024,
  parameter int WORD      = 32,
  parameter int DRAIN_CYC = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DIM-1:0]  sign_bits,
  output logic            cnt_clear,
  output logic [WORD-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic            busy,
  output logic            done
);

  localparam int NWORDS = DIM / WORD;
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_SEND  = 2'd3;

  localparam logic [IW-1:0] LAST_IDX   = IW'(NWORDS - 1);
  localparam logic [3:0]    DRAIN_INIT = 4'(DRAIN_CYC);

  logic [1:0]      state_q, state_d;
  logic [3:0]      drain_q, drain_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DIM-1:0]  snap_q, snap_d;
  logic            cnt_clear_q, cnt_clear_d;
  logic [WORD-1:0] m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [WORD-1:0] word_s;

  // Control path: state, drain countdown, word index and snapshot capture.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (DRAIN_INIT == 4'd0) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - 4'd1;
        if (drain_q <= 4'd1) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_LOAD: begin
        snap_d  = sign_bits;
        idx_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (m_valid_q && m_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Word selected by the next index; reads snap_d so the first word is ready straight out of LOAD.
  always_comb begin
    word_s = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (idx_d == IW'(w)) begin
        word_s = snap_d[w*WORD +: WORD];
      end else begin
        word_s = word_s;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    cnt_clear_d = (state_d == ST_LOAD);
    m_valid_d   = (state_d == ST_SEND);
    m_last_d    = (state_d == ST_SEND) && (idx_d == LAST_IDX);
    busy_d      = (state_d != ST_IDLE);
    if (state_d == ST_SEND) begin
      m_data_d = word_s;
    end else begin
      m_data_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_q     <= 4'd0;
      idx_q       <= '0;
      snap_q      <= '0;
      cnt_clear_q <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      cnt_clear_q <= cnt_clear_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cnt_clear = cnt_clear_q;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_hv_sign_packer.sv
// Directed bench for hv_sign_packer: one instance with a drain phase and two words,
// one with no drain and a single word.
module tb_hv_sign_packer;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_start, a_ready, a_clear, a_valid, a_last, a_busy, a_done;
  logic [63:0] a_sign;
  logic [31:0] a_data;

  logic        b_start, b_ready, b_clear, b_valid, b_last, b_busy, b_done;
  logic [31:0] b_sign;
  logic [31:0] b_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hv_sign_packer #(.DIM(64), .WORD(32), .DRAIN_CYC(3)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .sign_bits(a_sign),
    .cnt_clear(a_clear), .m_data(a_data), .m_valid(a_valid), .m_ready(a_ready),
    .m_last(a_last), .busy(a_busy), .done(a_done)
  );

  hv_sign_packer #(.DIM(32), .WORD(32), .DRAIN_CYC(0)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .sign_bits(b_sign),
    .cnt_clear(b_clear), .m_data(b_data), .m_valid(b_valid), .m_ready(b_ready),
    .m_last(b_last), .busy(b_busy), .done(b_done)
  );

  // Observation vector layout: {cnt_clear, m_valid, m_last, busy, done, m_data}.
  function automatic logic [36:0] pack(input logic clr, input logic vld, input logic lst,
                                       input logic bsy, input logic dn, input logic [31:0] d);
    return {clr, vld, lst, bsy, dn, d};
  endfunction

  // Expected outputs of instance a for an unstalled read-out started in cycle 0.
  function automatic logic [36:0] exp_plain(input int c);
    logic [31:0] d;
    d = (c == 5) ? 32'h01234567 : (c == 6) ? 32'hDEADBEEF : 32'h0;
    return pack(c == 4, c == 5 || c == 6, c == 6, c >= 1 && c <= 6, c == 7, d);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_start = 1'b0; a_ready = 1'b1; a_sign = 64'hFFFF_FFFF_FFFF_FFFF;
    b_start = 1'b0; b_ready = 1'b1; b_sign = 32'hFFFF_FFFF;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    checks++;
    if ({a_clear, a_valid, a_last, a_busy, a_done, a_data} !== 37'h0) begin
      failures++;
      $display("FAIL reset_a got=%h exp=%h", {a_clear, a_valid, a_last, a_busy, a_done, a_data}, 37'h0);
    end
    checks++;
    if ({b_clear, b_valid, b_last, b_busy, b_done, b_data} !== 37'h0) begin
      failures++;
      $display("FAIL reset_b got=%h exp=%h", {b_clear, b_valid, b_last, b_busy, b_done, b_data}, 37'h0);
    end
    next_cycle();
  endtask

  task automatic test_basic();
    logic [36:0] e;
    a_sign = 64'hDEADBEEF_01234567;
    a_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      a_start = (c == 0);
      e = exp_plain(c);
      checks++;
      if ({a_clear, a_valid, a_last, a_busy, a_done, a_data} !== e) begin
        failures++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", c, {a_clear, a_valid, a_last, a_busy, a_done, a_data}, e);
      end
      next_cycle();
    end
    a_start = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [36:0] e;
    logic [31:0] d;
    a_sign = 64'hDEADBEEF_01234567;
    for (int c = 0; c < 15; c++) begin
      a_start = (c == 0);
      a_ready = !(c >= 5 && c <= 9);
      d = (c >= 5 && c <= 10) ? 32'h01234567 : (c == 11) ? 32'hDEADBEEF : 32'h0;
      e = pack(c == 4, c >= 5 && c <= 11, c == 11, c >= 1 && c <= 11, c == 12, d);
      checks++;
      if ({a_clear, a_valid, a_last, a_busy, a_done, a_data} !== e) begin
        failures++;
        $display("FAIL backpressure cyc=%0d got=%h exp=%h", c, {a_clear, a_valid, a_last, a_busy, a_done, a_data}, e);
      end
      next_cycle();
    end
    a_start = 1'b0;
    a_ready = 1'b1;
  endtask

  task automatic test_start_ignored();
    logic [36:0] e;
    a_sign = 64'hDEADBEEF_01234567;
    a_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      a_start = (c == 0 || c == 2 || c == 5);
      e = exp_plain(c);
      checks++;
      if ({a_clear, a_valid, a_last, a_busy, a_done, a_data} !== e) begin
        failures++;
        $display("FAIL start_ignored cyc=%0d got=%h exp=%h", c, {a_clear, a_valid, a_last, a_busy, a_done, a_data}, e);
      end
      next_cycle();
    end
    a_start = 1'b0;
  endtask

  task automatic test_snapshot_hold();
    logic [36:0] e;
    a_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      a_start = (c == 0);
      a_sign = (c >= 5) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hDEADBEEF_01234567;
      e = exp_plain(c);
      checks++;
      if ({a_clear, a_valid, a_last, a_busy, a_done, a_data} !== e) begin
        failures++;
        $display("FAIL snapshot_hold cyc=%0d got=%h exp=%h", c, {a_clear, a_valid, a_last, a_busy, a_done, a_data}, e);
      end
      next_cycle();
    end
    a_start = 1'b0;
    a_sign = 64'hDEADBEEF_01234567;
  endtask

  task automatic test_reset_mid();
    logic [36:0] e;
    logic [31:0] d;
    a_sign = 64'hDEADBEEF_01234567;
    a_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      a_start = (c == 0 || c == 8);
      rst = (c == 5);
      if (c <= 5) begin
        e = exp_plain(c);
      end else begin
        d = (c == 13) ? 32'h01234567 : (c == 14) ? 32'hDEADBEEF : 32'h0;
        e = pack(c == 12, c == 13 || c == 14, c == 14, c >= 9 && c <= 14, c == 15, d);
      end
      checks++;
      if ({a_clear, a_valid, a_last, a_busy, a_done, a_data} !== e) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", c, {a_clear, a_valid, a_last, a_busy, a_done, a_data}, e);
      end
      next_cycle();
    end
    rst = 1'b0;
    a_start = 1'b0;
  endtask

  task automatic test_no_drain();
    logic [36:0] e;
    b_sign = 32'hA5A5A5A5;
    b_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      b_start = (c == 0);
      e = pack(c == 1, c == 2, c == 2, c == 1 || c == 2, c == 3, (c == 2) ? 32'hA5A5A5A5 : 32'h0);
      checks++;
      if ({b_clear, b_valid, b_last, b_busy, b_done, b_data} !== e) begin
        failures++;
        $display("FAIL no_drain cyc=%0d got=%h exp=%h", c, {b_clear, b_valid, b_last, b_busy, b_done, b_data}, e);
      end
      next_cycle();
    end
    b_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_snapshot_hold();
    test_reset_mid();
    test_no_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
